// File: rtl/cdb_write_arbiter_pkg.sv
// Shared constants for the CDB write path: tag encodings, idle broadcast value, default widths.
package cdb_write_arbiter_pkg;

   localparam int unsigned N_SRC_DEF  = 3;
   localparam int unsigned TAG_W_DEF  = 4;
   localparam int unsigned DATA_W_DEF = 16;

   // Reservation-station tags as seen on Qi_CDB.
   typedef enum logic [TAG_W_DEF-1:0] {
      TagNone = 4'd0,
      TagAdd1 = 4'd1,
      TagAdd2 = 4'd2
   } station_tag_e;

   localparam logic [TAG_W_DEF-1:0]  TAG_NONE  = TagNone;
   localparam logic [DATA_W_DEF-1:0] SEM_VALOR = 16'hFFF0;

   // Pointer width that stays legal for a single source.
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_write_arbiter_if.sv
// Result-producer / CDB bundle between the functional units, the arbiter and its consumers.
interface cdb_write_arbiter_if
   import cdb_write_arbiter_pkg::*;
#(
   parameter int unsigned N_SRC  = N_SRC_DEF,
   parameter int unsigned TAG_W  = TAG_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) ();

   logic [N_SRC-1:0]        Req;
   logic [N_SRC*TAG_W-1:0]  Tag_in;
   logic [N_SRC*DATA_W-1:0] Data_in;
   logic [N_SRC-1:0]        Ack;
   logic                    CDB_Valid;
   logic [TAG_W-1:0]        Qi_CDB;
   logic [DATA_W-1:0]       Qi_CDB_data;
   logic [N_SRC-1:0]        Pending;

   // Producer side: functional units offering results and watching the bus.
   modport master (
      output Req, Tag_in, Data_in,
      input  Ack, CDB_Valid, Qi_CDB, Qi_CDB_data, Pending
   );

   // Arbiter side.
   modport slave (
      input  Req, Tag_in, Data_in,
      output Ack, CDB_Valid, Qi_CDB, Qi_CDB_data, Pending
   );

endinterface

// File: rtl/cdb_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned N_SRC = 3,
   parameter int unsigned PTR_W = 2
) (
   input  logic [N_SRC-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_SRC-1:0] grant,
   output logic [PTR_W-1:0] ptr_nxt
);

   int unsigned      idx;
   logic [PTR_W-1:0] sel;
   logic             found;

   // Scan ptr, ptr+1, ... mod N_SRC; grant the first hit and point just past it.
   always_comb begin
      grant   = '0;
      ptr_nxt = ptr;
      found   = 1'b0;
      idx     = 0;
      sel     = '0;
      for (int unsigned k = 0; k < N_SRC; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_SRC) begin
            idx = idx - N_SRC;
         end
         sel = PTR_W'(idx);
         if (!found && req[sel]) begin
            found      = 1'b1;
            grant[sel] = 1'b1;
            ptr_nxt    = (idx + 1 == N_SRC) ? '0 : PTR_W'(idx + 1);
         end
      end
   end

endmodule

// File: rtl/cdb_write_arbiter.sv
// Buffers one completed result per functional unit and broadcasts one per cycle on the CDB.
module cdb_write_arbiter
   import cdb_write_arbiter_pkg::*;
#(
   parameter int unsigned N_SRC  = N_SRC_DEF,
   parameter int unsigned TAG_W  = TAG_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input logic                Clock,
   input logic                Reset,
   cdb_write_arbiter_if.slave bus
);

   localparam int unsigned PTR_W = ptr_width(N_SRC);
   localparam logic [TAG_W-1:0]  TagIdle  = TAG_W'(TAG_NONE);
   localparam logic [DATA_W-1:0] DataIdle = DATA_W'(SEM_VALOR);

   logic [N_SRC-1:0]  valid_q, valid_d;
   logic [TAG_W-1:0]  tag_q  [N_SRC];
   logic [TAG_W-1:0]  tag_d  [N_SRC];
   logic [DATA_W-1:0] data_q [N_SRC];
   logic [DATA_W-1:0] data_d [N_SRC];
   logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_nxt;

   logic              cdb_valid_q, cdb_valid_d;
   logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
   logic [DATA_W-1:0] cdb_data_q, cdb_data_d;

   logic [N_SRC-1:0]  grant;
   logic [N_SRC-1:0]  ack;
   logic [N_SRC-1:0]  capture;

   rr_arbiter #(
      .N_SRC (N_SRC),
      .PTR_W (PTR_W)
   ) u_rr_arbiter (
      .req     (valid_q),
      .ptr     (ptr_q),
      .grant   (grant),
      .ptr_nxt (ptr_nxt)
   );

   // A slot being drained this cycle can take a new result, allowing back-to-back transfers.
   always_comb begin
      ack     = ~valid_q | grant;
      capture = '0;
      for (int i = 0; i < N_SRC; i++) begin
         // Untagged results are acked but silently dropped.
         capture[i] = bus.Req[i] & ack[i] & (bus.Tag_in[i*TAG_W +: TAG_W] != TagIdle);
      end
   end

   // Next-state for holding buffers, rr pointer and the broadcast register.
   always_comb begin
      valid_d     = valid_q;
      tag_d       = tag_q;
      data_d      = data_q;
      ptr_d       = ptr_nxt;
      cdb_valid_d = 1'b0;
      cdb_tag_d   = TagIdle;
      cdb_data_d  = DataIdle;
      for (int i = 0; i < N_SRC; i++) begin
         if (grant[i]) begin
            valid_d[i]  = 1'b0;
            cdb_valid_d = 1'b1;
            cdb_tag_d   = tag_q[i];
            cdb_data_d  = data_q[i];
         end
         // Refill wins over drain so a same-cycle capture stays buffered.
         if (capture[i]) begin
            valid_d[i] = 1'b1;
            tag_d[i]   = bus.Tag_in[i*TAG_W +: TAG_W];
            data_d[i]  = bus.Data_in[i*DATA_W +: DATA_W];
         end
      end
   end

   // State registers; reset discards everything, including the in-flight broadcast.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         valid_q     <= '0;
         ptr_q       <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= TagIdle;
         cdb_data_q  <= DataIdle;
      end else begin
         valid_q     <= valid_d;
         ptr_q       <= ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_data_q  <= cdb_data_d;
      end
   end

   // Payload storage needs no reset: it is only read while its valid bit is set.
   always_ff @(posedge Clock) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   assign bus.Ack         = ack;
   assign bus.Pending     = valid_q;
   assign bus.CDB_Valid   = cdb_valid_q;
   assign bus.Qi_CDB      = cdb_tag_q;
   assign bus.Qi_CDB_data = cdb_data_q;

endmodule
